// File: rtl/run_controller_pkg.sv
// Shared definitions for the run controller: FSM state encoding and parameter defaults.
package run_controller_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int START_CYCLES_DEFAULT = 2;
    localparam int TIMEOUT_DEFAULT      = 4096;

endpackage

// File: rtl/run_controller_run_timer.sv
// RUN-phase cycle counter with its TIMEOUT compare.
module run_timer
    import run_controller_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count,
    output logic        expired
);

    logic [15:0] elapsed;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            elapsed <= 16'd0;
        end else if (enable) begin
            elapsed <= elapsed + 16'd1;
        end
    end

    // count includes the current cycle, so the first enabled cycle reads 1
    assign count   = elapsed + 16'd1;
    assign expired = (count == 16'(TIMEOUT));

endmodule

// File: rtl/run_controller.sv
// Launch sequencer: preloads core data memory, pulses core_start, times the run and reports.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int START_CYCLES = START_CYCLES_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [7:0]  load_len,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        core_start,
    input  logic        core_done,
    output logic        busy,
    output logic        rpt_valid,
    output logic [15:0] rpt_cycles,
    output logic        rpt_timeout
);

    state_t      state;
    logic [7:0]  len_q;
    logic [7:0]  idx;
    logic [3:0]  start_cnt;
    logic [15:0] run_count;
    logic        run_expired;

    run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .count   (run_count),
        .expired (run_expired)
    );

    // Outputs are registered alongside the state so each reflects the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            len_q       <= 8'd0;
            idx         <= 8'd0;
            start_cnt   <= 4'd0;
            ld_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 8'd0;
            mem_wdata   <= 8'd0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            rpt_valid   <= 1'b0;
            rpt_cycles  <= 16'd0;
            rpt_timeout <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rpt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        len_q     <= load_len;
                        idx       <= 8'd0;
                        start_cnt <= 4'd0;
                        busy      <= 1'b1;
                        if (load_len != 8'd0) begin
                            state    <= LOAD;
                            ld_ready <= 1'b1;
                        end else begin
                            state      <= START;
                            core_start <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx;
                        mem_wdata <= ld_data;
                        idx       <= idx + 8'd1;
                        if (idx == len_q - 8'd1) begin
                            state      <= START;
                            ld_ready   <= 1'b0;
                            core_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    start_cnt <= start_cnt + 4'd1;
                    if (start_cnt == 4'(START_CYCLES - 1)) begin
                        state      <= RUN;
                        core_start <= 1'b0;
                    end
                end
                RUN: begin
                    // Completion wins over a simultaneous timeout.
                    if (core_done) begin
                        state       <= REPORT;
                        rpt_valid   <= 1'b1;
                        rpt_cycles  <= run_count;
                        rpt_timeout <= 1'b0;
                    end else if (run_expired) begin
                        state       <= REPORT;
                        rpt_valid   <= 1'b1;
                        rpt_cycles  <= 16'(TIMEOUT);
                        rpt_timeout <= 1'b1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
